// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window buffer: default geometry, window
// element indices and the coordinate-width helper.
package sobel_pkg;

  localparam int DEF_IMG_W  = 5;
  localparam int DEF_IMG_H  = 5;
  localparam int DEF_DATA_W = 8;

  // Window element k = 3*row_offset + col_offset, top-left first.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_window_buffer_if.sv
// Pixel-in / window-out bundle of the Sobel window buffer; the slave modport
// is the buffer side, the master modport is the upstream/downstream side.
interface sobel_window_buffer_if
  import sobel_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_pixel;
  logic [RW-1:0]         in_row;
  logic [CW-1:0]         in_col;
  logic                  win_valid;
  logic [9*DATA_W-1:0]   win;
  logic [RW-1:0]         win_row;
  logic [CW-1:0]         win_col;
  logic                  frame_done;
  logic                  seq_err;

  modport slave (
    input  in_valid, in_pixel, in_row, in_col,
    output win_valid, win, win_row, win_col, frame_done, seq_err
  );

  modport master (
    output in_valid, in_pixel, in_row, in_col,
    input  win_valid, win, win_row, win_col, frame_done, seq_err
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of history: combinational read and enabled write at the same
// column, so a read-before-write swap happens within one cycle.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = DEF_IMG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = coord_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              in_range;

  // Columns past the image width (non power-of-two widths) neither read nor write.
  assign in_range = (int'(addr_i) < DEPTH);
  assign rd_dat_o = in_range ? mem_q[addr_i] : '0;

  always_ff @(posedge clk) begin
    if (wr_en_i && in_range) begin
      mem_q[addr_i] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 window builder: two line buffers plus a shift window; a window
// is emitted one cycle after each accepted pixel with row>=2 and col>=2.
module sobel_window_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_window_buffer_if.slave  bus
);

  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic              accept;
  logic              emit;
  logic              last_px;
  logic [DATA_W-1:0] top_rd;
  logic [DATA_W-1:0] mid_rd;

  logic [DATA_W-1:0] wreg_q [9];
  logic [DATA_W-1:0] wreg_d [9];
  logic [DATA_W-1:0] win_q  [9];
  logic              win_vld_q, win_vld_d;
  logic [RW-1:0]     win_row_q, win_row_d;
  logic [CW-1:0]     win_col_q, win_col_d;
  logic              frame_done_q, frame_done_d;
  logic              seq_err_q, seq_err_d;
  logic [RW-1:0]     exp_row_q, exp_row_d;
  logic [CW-1:0]     exp_col_q, exp_col_d;

  // Reset wins over a same-cycle pixel, including the line-buffer write.
  assign accept  = bus.in_valid & ~rst;
  assign emit    = accept && (bus.in_row >= RW'(2)) && (bus.in_col >= CW'(2));
  assign last_px = (bus.in_row == LAST_ROW) && (bus.in_col == LAST_COL);

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb_top (
    .clk      (clk),
    .wr_en_i  (accept),
    .addr_i   (bus.in_col),
    .wr_dat_i (mid_rd),
    .rd_dat_o (top_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb_mid (
    .clk      (clk),
    .wr_en_i  (accept),
    .addr_i   (bus.in_col),
    .wr_dat_i (bus.in_pixel),
    .rd_dat_o (mid_rd)
  );

  always_comb begin
    wreg_d[WIN_TL] = wreg_q[WIN_TC];
    wreg_d[WIN_TC] = wreg_q[WIN_TR];
    wreg_d[WIN_TR] = top_rd;
    wreg_d[WIN_ML] = wreg_q[WIN_MC];
    wreg_d[WIN_MC] = wreg_q[WIN_MR];
    wreg_d[WIN_MR] = mid_rd;
    wreg_d[WIN_BL] = wreg_q[WIN_BC];
    wreg_d[WIN_BC] = wreg_q[WIN_BR];
    wreg_d[WIN_BR] = bus.in_pixel;
  end

  always_comb begin
    win_vld_d    = emit;
    frame_done_d = emit && last_px;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    if (emit) begin
      win_row_d = bus.in_row - RW'(1);
      win_col_d = bus.in_col - CW'(1);
    end
  end

  // The checker resyncs to the received tag, so one glitch flags only once.
  always_comb begin
    seq_err_d = seq_err_q;
    exp_row_d = exp_row_q;
    exp_col_d = exp_col_q;
    if (accept) begin
      if ((bus.in_row != exp_row_q) || (bus.in_col != exp_col_q)) begin
        seq_err_d = 1'b1;
      end
      if (bus.in_col == LAST_COL) begin
        exp_col_d = '0;
        exp_row_d = (bus.in_row == LAST_ROW) ? '0 : bus.in_row + RW'(1);
      end else begin
        exp_col_d = bus.in_col + CW'(1);
        exp_row_d = bus.in_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        wreg_q[k] <= '0;
        win_q[k]  <= '0;
      end
      win_vld_q    <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      exp_row_q    <= '0;
      exp_col_q    <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < 9; k++) wreg_q[k] <= wreg_d[k];
      end
      if (emit) begin
        for (int k = 0; k < 9; k++) win_q[k] <= wreg_d[k];
      end
      win_vld_q    <= win_vld_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      exp_row_q    <= exp_row_d;
      exp_col_q    <= exp_col_d;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_win
    assign bus.win[k*DATA_W +: DATA_W] = win_q[k];
  end

  assign bus.win_valid  = win_vld_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seq_err    = seq_err_q;

endmodule
